// File: rtl/icache.sv
// icache: direct-mapped instruction cache returning 32 bits at a halfword-aligned pc.
// Define ICACHE_BYPASS_EN to build without storage (every request goes to memory).
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        to_icache,
    input  logic [31:0] pc_to_icache,
    output logic        have_result,
    output logic [31:0] inst_from_icache,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);
    typedef enum logic [1:0] {IDLE, MISS0, MISS1, RESP} state_e;

    state_e      state_q;
    logic [31:0] pc_q, w0_q, w1_q, inst_q, mem_addr_q;
    logic        have_result_q, mem_req_q;
    logic [31:0] w0, w1, rd0, rd1;
    logic        need1, hit0, hit1;

    // Lookups use the incoming pc while idle and the latched pc during a miss.
    assign w0    = (state_q == IDLE ? pc_to_icache : pc_q) & ~32'd3;
    assign w1    = w0 + 32'd4;
    assign need1 = state_q == IDLE ? pc_to_icache[1] : pc_q[1];

`ifdef ICACHE_BYPASS_EN
    assign hit0 = 1'b0;
    assign hit1 = 1'b0;
    assign rd0  = '0;
    assign rd1  = '0;
`else
    localparam int N  = 1 << INDEX_BITS;
    localparam int TW = 30 - INDEX_BITS;

    logic [N-1:0]          valid_q;
    logic [TW-1:0]         tag_q [N];
    logic [31:0]           data_q [N];
    logic [INDEX_BITS-1:0] idx0, idx1, fill_idx;
    logic [TW-1:0]         tag0, tag1, fill_tag;
    logic                  fill;

    assign idx0     = w0[INDEX_BITS+1:2];
    assign idx1     = w1[INDEX_BITS+1:2];
    assign tag0     = w0[31:INDEX_BITS+2];
    assign tag1     = w1[31:INDEX_BITS+2];
    assign fill     = rdy_in && mem_ready && (state_q == MISS0 || state_q == MISS1);
    assign fill_idx = state_q == MISS0 ? idx0 : idx1;
    assign fill_tag = state_q == MISS0 ? tag0 : tag1;
    assign rd0      = data_q[idx0];
    assign rd1      = data_q[idx1];
    assign hit0     = valid_q[idx0] && tag_q[idx0] == tag0;
    // A W1 sharing W0's index is evicted by the W0 fill, so it never counts as a hit.
    assign hit1     = valid_q[idx1] && tag_q[idx1] == tag1 && idx1 != idx0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            valid_q <= '0;
        else if (fill)
            valid_q[fill_idx] <= 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data;
        end
    end
`endif

    function automatic logic [31:0] pack(input logic hi, input logic [31:0] a, input logic [31:0] b);
        return hi ? {b[15:0], a[31:16]} : a;
    endfunction

    // Words are captured into w0_q/w1_q so the response never re-reads storage.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            w0_q          <= '0;
            w1_q          <= '0;
            inst_q        <= '0;
            have_result_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else if (rdy_in) begin
            case (state_q)
                IDLE: if (to_icache) begin
                    pc_q <= pc_to_icache;
                    w0_q <= rd0;
                    w1_q <= rd1;
                    if (hit0 && (!need1 || hit1)) begin
                        state_q       <= RESP;
                        have_result_q <= 1'b1;
                        inst_q        <= pack(need1, rd0, rd1);
                    end else begin
                        state_q    <= hit0 ? MISS1 : MISS0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= hit0 ? w1 : w0;
                    end
                end
                MISS0: if (mem_ready) begin
                    w0_q <= mem_data;
                    if (need1 && !hit1) begin
                        state_q    <= MISS1;
                        mem_addr_q <= w1;
                    end else begin
                        state_q       <= RESP;
                        mem_req_q     <= 1'b0;
                        have_result_q <= 1'b1;
                        inst_q        <= pack(need1, mem_data, w1_q);
                    end
                end
                MISS1: if (mem_ready) begin
                    w1_q          <= mem_data;
                    state_q       <= RESP;
                    mem_req_q     <= 1'b0;
                    have_result_q <= 1'b1;
                    inst_q        <= pack(need1, w0_q, mem_data);
                end
                RESP: begin
                    state_q       <= IDLE;
                    have_result_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign have_result      = have_result_q;
    assign inst_from_icache = inst_q;
    assign mem_req          = mem_req_q;
    assign mem_addr         = mem_addr_q;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scoreboard bench for icache with a fixed-latency memory model.
module tb_icache;
    logic        clk_in, rst_in, rdy_in, to_icache, mem_ready;
    logic [31:0] pc_to_icache, mem_data;
    logic        have_result, mem_req;
    logic [31:0] inst_from_icache, mem_addr;

`ifdef ICACHE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = 3;

    int          checks, errors, reads, cnt;
    bit          stray;
    logic [31:0] exp_inst[$];
    logic [31:0] exp_addr[$];

    icache #(.INDEX_BITS(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .to_icache(to_icache),
        .pc_to_icache(pc_to_icache), .have_result(have_result),
        .inst_from_icache(inst_from_icache), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_data(mem_data)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h1FC) return 32'hAAAA1111;
        if (a == 32'h200) return 32'h2222BBBB;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory: answers each request LAT unpaused cycles after it is seen.
    initial begin
        logic [31:0] ea;
        mem_ready = 1'b0;
        mem_data  = '0;
        cnt       = 0;
        forever begin
            @(negedge clk_in);
            mem_ready = 1'b0;
            if (stray) begin
                mem_ready = 1'b1;
                mem_data  = 32'hDEADBEEF;
                stray     = 1'b0;
            end else if (!rst_in || !mem_req) begin
                cnt = 0;
            end else if (rdy_in) begin
                cnt++;
                if (cnt == LAT) begin
                    mem_ready = 1'b1;
                    mem_data  = memword(mem_addr);
                    reads++;
                    cnt = 0;
                    checks++;
                    if (exp_addr.size() == 0) begin
                        errors++;
                        $display("FAIL mem_addr: unexpected read of %h", mem_addr);
                    end else begin
                        ea = exp_addr.pop_front();
                        if (mem_addr !== ea) begin
                            errors++;
                            $display("FAIL mem_addr: got %h expected %h", mem_addr, ea);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (have_result) begin
            checks++;
            if (exp_inst.size() == 0) begin
                errors++;
                $display("FAIL inst: unexpected have_result with %h", inst_from_icache);
            end else begin
                logic [31:0] e;
                e = exp_inst.pop_front();
                if (inst_from_icache !== e) begin
                    errors++;
                    $display("FAIL inst: got %h expected %h", inst_from_icache, e);
                end
            end
        end
    end

    task automatic req(input string name, input logic [31:0] pc, input logic [31:0] inst,
                       input int nreads, input logic [31:0] a0, input logic [31:0] a1,
                       input int extra);
        int n, r0, nr;
        logic [31:0] b0, b1;
        nr = nreads;
        b0 = a0;
        b1 = a1;
        if (BYP) begin
            nr = pc[1] ? 2 : 1;
            b0 = pc & ~32'd3;
            b1 = b0 + 32'd4;
        end
        if (nr > 0) exp_addr.push_back(b0);
        if (nr > 1) exp_addr.push_back(b1);
        exp_inst.push_back(inst);
        r0 = reads;
        pc_to_icache = pc;
        to_icache    = 1'b1;
        @(posedge clk_in);
        #1 to_icache = 1'b0;
        chk({name, " mem_req_start"}, 32'(mem_req), 32'(nr > 0));
        n = 0;
        while (n < 60) begin
            @(negedge clk_in);
            n++;
            if (have_result) break;
        end
        chk({name, " latency"}, 32'(n), 32'(nr * LAT + 1 + extra));
        chk({name, " reads"}, 32'(reads - r0), 32'(nr));
        chk({name, " mem_req_end"}, 32'(mem_req), 32'd0);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; reads = 0; stray = 1'b0;
        rst_in = 1'b0; rdy_in = 1'b1; to_icache = 1'b0; pc_to_icache = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset have_result", 32'(have_result), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset inst", inst_from_icache, 32'd0);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        req("cold", 32'h100, 32'h0100FEFF, 1, 32'h100, 0, 0);
        req("rehit", 32'h100, 32'h0100FEFF, 0, 0, 0, 0);
        req("straddle_miss", 32'h1FE, 32'hBBBBAAAA, 2, 32'h1FC, 32'h200, 0);
        req("straddle_hit", 32'h1FE, 32'hBBBBAAAA, 0, 0, 0, 0);
        req("evict200", 32'h000, 32'h0000FFFF, 1, 32'h000, 0, 0);
        req("straddle_w1", 32'h1FE, 32'hBBBBAAAA, 1, 32'h200, 0, 0);
        req("conf_fill", 32'h000, 32'h0000FFFF, 1, 32'h000, 0, 0);
        req("conf_other", 32'h100, 32'h0100FEFF, 1, 32'h100, 0, 0);
        req("conf_refetch", 32'h000, 32'h0000FFFF, 1, 32'h000, 0, 0);
        req("wrap", 32'hFFFFFFFE, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 0);
        fork
            req("pause", 32'h300, 32'h0300FCFF, 1, 32'h300, 0, 5);
            begin
                @(posedge clk_in);
                @(posedge clk_in);
                #1 rdy_in = 1'b0;
                @(negedge clk_in);
                chk("pause mem_req", 32'(mem_req), 32'd1);
                chk("pause mem_addr", mem_addr, 32'h300);
                repeat (5) @(posedge clk_in);
                #1 rdy_in = 1'b1;
            end
        join
        pc_to_icache = 32'h400;
        to_icache    = 1'b1;
        @(posedge clk_in);
        #1 to_icache = 1'b0;
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        chk("midreset have_result", 32'(have_result), 32'd0);
        chk("midreset mem_req", 32'(mem_req), 32'd0);
        chk("midreset mem_addr", mem_addr, 32'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        stray = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        chk("stray have_result", 32'(have_result), 32'd0);
        chk("stray mem_req", 32'(mem_req), 32'd0);
        req("post_reset_300", 32'h300, 32'h0300FCFF, 1, 32'h300, 0, 0);
        req("post_reset_100", 32'h100, 32'h0100FEFF, 1, 32'h100, 0, 0);
        repeat (3) @(posedge clk_in);
        chk("inst queue drained", 32'(exp_inst.size()), 32'd0);
        chk("addr queue drained", 32'(exp_addr.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, log2 of the number of direct-mapped 32-bit word entries.
REQ-002 SHALL have port clk_in  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rdy_in  input  1  global pause, active-low.
REQ-005 SHALL have port to_icache  input  1  fetch request strobe from ifetch; a one-cycle pulse.
REQ-006 SHALL have port pc_to_icache  input  32  fetch address; halfword-aligned, with bit 0 equal to 0.
REQ-007 SHALL have port have_result  output  1  one-cycle response pulse to ifetch.
REQ-008 SHALL have port inst_from_icache  output  32  the 32 instruction bits starting at the requested pc.
REQ-009 SHALL have port mem_req  output  1  word read request to the memory controller, held high until accepted.
REQ-010 SHALL have port mem_addr  output  32  word-aligned read address.
REQ-011 SHALL have port mem_ready  input  1  one-cycle pulse: mem_data is valid and the request is complete.
REQ-012 SHALL have port mem_data  input  32  read data returned by memory.

Function
REQ-013 Storage SHALL be 2^INDEX_BITS entries, each holding a valid bit, a tag of pc[31:INDEX_BITS+2] and one data word; the index is pc[INDEX_BITS+1:2].
REQ-014 The FSM SHALL have states IDLE, MISS0, MISS1 and RESP.
REQ-015 In IDLE, a to_icache pulse SHALL latch pc_to_icache; to_icache pulses in any other state SHALL be ignored.
REQ-016 Word W0 is pc & ~3 and word W1 is W0+4; W1 is needed only when pc[1]=1.
REQ-017 When all needed words hit, the block SHALL go to RESP; have_result SHALL be 1 in the cycle after the strobe (1-cycle hit latency).
REQ-018 When W0 misses, the block SHALL go to MISS0 with mem_req=1 and mem_addr=W0.
REQ-019 On mem_ready in MISS0, the block SHALL fill the W0 entry, then go to MISS1 if W1 is needed and misses, else to RESP.
REQ-020 MISS1 SHALL behave like MISS0 but for W1.
REQ-021 When W0 hits but a needed W1 misses, the block SHALL go directly to MISS1.
REQ-022 In RESP, have_result SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-023 In RESP, inst_from_icache SHALL equal word(W0) when pc[1]=0, else {word(W1)[15:0], word(W0)[31:16]}.
REQ-024 When pc[1]=1 and W0 and W1 map to the same index, the response SHALL use the words captured during this request, not re-read entries.
REQ-025 mem_addr SHALL stay stable while mem_req=1; mem_req SHALL drop in the cycle after mem_ready.
REQ-026 A started request SHALL always complete with a have_result pulse, even if ifetch has abandoned it; ifetch discards stale results.
REQ-027 Index wrap-around SHALL be handled: W0=0xFFFFFFFC gives W1=0x00000000 (modulo 2^32).
REQ-028 While rdy_in=0, state, outputs and storage SHALL hold, and mem_ready SHALL be ignored; the memory side pauses on rdy_in too.

Reset
REQ-029 rst_in=0 SHALL asynchronously clear all valid bits, set the FSM to IDLE, and set have_result, mem_req, mem_addr and inst_from_icache to 0.
REQ-030 Reset mid-miss SHALL abandon the miss; a mem_ready arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-031 With macro ICACHE_BYPASS_EN defined, no storage SHALL be built and every request SHALL take the miss path (MISS0, then MISS1 if pc[1]=1).
REQ-032 Without ICACHE_BYPASS_EN, the cached behaviour of REQ-013 to REQ-028 SHALL apply.

Verification
REQ-033 Cold miss: strobe pc=0x100 with memory latency 3 -> mem_addr=0x100; have_result one cycle after mem_ready; inst equals mem word 0x100.
REQ-034 Rehit: repeat pc=0x100 -> have_result in the next cycle with no mem_req.
REQ-035 Straddle: pc=0x1FE with word 0x1FC=0xAAAA1111 and word 0x200=0x2222BBBB -> inst=0xBBBBAAAA; two memory reads when both miss, one read when 0x1FC is cached.
REQ-036 Conflict: fill pc=0x000, then pc=0x100 (same index at INDEX_BITS=6), then pc=0x000 -> the third request misses and refetches.
REQ-037 Pause and reset: rdy_in=0 for 5 cycles mid-miss -> mem_req/mem_addr unchanged, response delayed by 5; rst_in=0 mid-miss -> immediate IDLE, have_result=0, then pc=0x100 misses.
REQ-038 Bypass build: ICACHE_BYPASS_EN defined, pc=0x100 requested twice -> two memory reads.
